// File: rtl/wb_bram_slave.sv
// WISHBONE classic-cycle slave around an inferred single-port block RAM.
// It supports byte-lane writes, a read latency of 1 or 2 clocks, and ERR_O for out-of-range addresses.
module wb_bram_slave #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 3,
    parameter int DEPTH        = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                    CLK_I,
    input  logic                    RST_I,
    input  logic                    CYC_I,
    input  logic                    STB_I,
    input  logic                    WE_I,
    input  logic [ADDR_WIDTH-1:0]   ADR_I,
    input  logic [DATA_WIDTH/8-1:0] SEL_I,
    input  logic [DATA_WIDTH-1:0]   DAT_I,
    output logic [DATA_WIDTH-1:0]   DAT_O,
    output logic                    ACK_O,
    output logic                    ERR_O
);

    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        TERM
    } state_e;

    state_e                  state_q;
    logic                    ack_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   dat_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic req;
    logic inrange;
    logic wr_en;

    assign req     = CYC_I & STB_I;
    assign inrange = ({1'b0, ADR_I} < DEPTH_L);
    assign wr_en   = ~RST_I & (state_q == IDLE) & req & WE_I & inrange;

    // NOTE: the RAM array has no reset, so it can map onto block RAM; only control and output registers are reset.
    always_ff @(posedge CLK_I) begin
        if (wr_en) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (SEL_I[i]) begin
                    mem[ADR_I][8*i +: 8] <= DAT_I[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
            addr_q  <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        addr_q <= ADR_I;
                        if (!inrange) begin
                            err_q   <= 1'b1;
                            state_q <= TERM;
                        end else if (WE_I) begin
                            ack_q   <= 1'b1;
                            state_q <= TERM;
                        end else if (READ_LATENCY == 1) begin
                            ack_q   <= 1'b1;
                            dat_q   <= mem[ADR_I];
                            state_q <= TERM;
                        end else begin
                            state_q <= RD_WAIT;
                        end
                    end
                end
                // The read uses the captured address, so later ADR_I changes are ignored.
                RD_WAIT: begin
                    if (req) begin
                        ack_q   <= 1'b1;
                        dat_q   <= mem[addr_q];
                        state_q <= TERM;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                TERM:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign DAT_O = dat_q;
    assign ACK_O = ack_q;
    assign ERR_O = err_q;

endmodule

// File: tb/tb_wb_bram_slave.sv
// Self-checking bench for wb_bram_slave: three instances cover latency 1, latency 2 and DEPTH < 2**ADDR_WIDTH.
// It combines directed vectors, abort and reset sequences, and random transfers checked against an array model.
module tb_wb_bram_slave;

    localparam int NDUT = 3;
    localparam int DEPTH_K [NDUT] = '{8, 8, 6};
    localparam int RL_K    [NDUT] = '{1, 2, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [NDUT];
    logic        cyc  [NDUT];
    logic        stb  [NDUT];
    logic        we   [NDUT];
    logic [2:0]  adr  [NDUT];
    logic [3:0]  sel  [NDUT];
    logic [31:0] dati [NDUT];
    logic [31:0] dato [NDUT];
    logic        ack  [NDUT];
    logic        err  [NDUT];

    wb_bram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .DEPTH(8), .READ_LATENCY(1)) u_dut0 (
        .CLK_I(clk), .RST_I(rst[0]), .CYC_I(cyc[0]), .STB_I(stb[0]), .WE_I(we[0]),
        .ADR_I(adr[0]), .SEL_I(sel[0]), .DAT_I(dati[0]), .DAT_O(dato[0]),
        .ACK_O(ack[0]), .ERR_O(err[0]));

    wb_bram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .DEPTH(8), .READ_LATENCY(2)) u_dut1 (
        .CLK_I(clk), .RST_I(rst[1]), .CYC_I(cyc[1]), .STB_I(stb[1]), .WE_I(we[1]),
        .ADR_I(adr[1]), .SEL_I(sel[1]), .DAT_I(dati[1]), .DAT_O(dato[1]),
        .ACK_O(ack[1]), .ERR_O(err[1]));

    wb_bram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .DEPTH(6), .READ_LATENCY(1)) u_dut2 (
        .CLK_I(clk), .RST_I(rst[2]), .CYC_I(cyc[2]), .STB_I(stb[2]), .WE_I(we[2]),
        .ADR_I(adr[2]), .SEL_I(sel[2]), .DAT_I(dati[2]), .DAT_O(dato[2]),
        .ACK_O(ack[2]), .ERR_O(err[2]));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: contents of each instance's memory, plus the last word each instance returned.
    logic [31:0] model_mem   [NDUT][8];
    bit          model_valid [NDUT][8];
    logic [31:0] last_dat    [NDUT];

    typedef struct {
        int          k;
        bit          we;
        logic [2:0]  adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        bit          exp_err;
        bit          chk_dat;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_write(input int k, input logic [2:0] a, input logic [3:0] s, input logic [31:0] d);
        for (int i = 0; i < 4; i++) begin
            if (s[i]) model_mem[k][a][8*i +: 8] = d[8*i +: 8];
        end
        if (s == 4'hF) model_valid[k][a] = 1'b1;
    endtask

    // Holds the request until a termination or a 5-cycle budget expires. The address is scrambled after the capture edge.
    task automatic xfer(input int k, input bit w, input logic [2:0] a, input logic [3:0] s,
                        input logic [31:0] d, output bit got_ack, output bit got_err,
                        output int lat, output logic [31:0] rdata);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; sel[k] = s; dati[k] = d;
        got_ack = 1'b0; got_err = 1'b0; lat = -1; rdata = '0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (ack[k] || err[k]) begin
                got_ack = ack[k]; got_err = err[k]; lat = c; rdata = dato[k];
                break;
            end
            if (c == 1) adr[k] = 3'($urandom);
        end
        cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run(input int k, input bit w, input logic [2:0] a, input logic [3:0] s,
                       input logic [31:0] d, input bit exp_err, input bit chk_dat,
                       input logic [31:0] exp_dat, input string name);
        bit          got_ack, got_err;
        int          lat, exp_lat;
        logic [31:0] rdata;
        exp_lat = (exp_err || w) ? 1 : RL_K[k];
        xfer(k, w, a, s, d, got_ack, got_err, lat, rdata);
        check($sformatf("%s_d%0d_a%0d_ack", name, k, a), 32'(got_ack), 32'(!exp_err));
        check($sformatf("%s_d%0d_a%0d_err", name, k, a), 32'(got_err), 32'(exp_err));
        check($sformatf("%s_d%0d_a%0d_latency", name, k, a), 32'(lat), 32'(exp_lat));
        if (!w && !exp_err && chk_dat)
            check($sformatf("%s_d%0d_a%0d_rdata", name, k, a), rdata, exp_dat);
        if (exp_err)
            check($sformatf("%s_d%0d_a%0d_dat_hold", name, k, a), rdata, last_dat[k]);
        check($sformatf("%s_d%0d_a%0d_pulse_width", name, k, a), 32'(ack[k] | err[k]), 32'd0);
        if (got_ack && !w) last_dat[k] = rdata;
        if (w && !exp_err) model_write(k, a, s, d);
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            rst[k] = 1'b1; cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
            adr[k] = '0; sel[k] = '0; dati[k] = '0; last_dat[k] = '0;
            for (int a = 0; a < 8; a++) begin
                model_mem[k][a] = '0; model_valid[k][a] = 1'b0;
            end
        end

        // Reset for two clocks, then stay idle.
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (c == 1) for (int k = 0; k < NDUT; k++) rst[k] = 1'b0;
            for (int k = 0; k < NDUT; k++) begin
                check($sformatf("idle_c%0d_d%0d_ack", c, k), 32'(ack[k]), 32'd0);
                check($sformatf("idle_c%0d_d%0d_err", c, k), 32'(err[k]), 32'd0);
                check($sformatf("idle_c%0d_d%0d_dat", c, k), dato[k], 32'd0);
            end
        end

        // Directed vectors: {dut, we, adr, sel, wdata, exp_err, check_data, exp_data}.
        vecs.push_back('{0, 1'b1, 3'd5, 4'hF,    32'hDEADBEEF, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{0, 1'b0, 3'd5, 4'h0,    32'h0,        1'b0, 1'b1, 32'hDEADBEEF});
        vecs.push_back('{0, 1'b1, 3'd2, 4'hF,    32'h11223344, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{0, 1'b1, 3'd2, 4'b0101, 32'hAABBCCDD, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{0, 1'b0, 3'd2, 4'hF,    32'h0,        1'b0, 1'b1, 32'h11BB33DD});
        vecs.push_back('{0, 1'b1, 3'd3, 4'hF,    32'h12345678, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{0, 1'b1, 3'd3, 4'h0,    32'hFFFFFFFF, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{0, 1'b0, 3'd3, 4'h0,    32'h0,        1'b0, 1'b1, 32'h12345678});
        vecs.push_back('{0, 1'b1, 3'd7, 4'hF,    32'h0BADF00D, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{0, 1'b0, 3'd7, 4'hF,    32'h0,        1'b0, 1'b1, 32'h0BADF00D});
        vecs.push_back('{1, 1'b1, 3'd5, 4'hF,    32'h5A5A1234, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1, 1'b0, 3'd5, 4'hF,    32'h0,        1'b0, 1'b1, 32'h5A5A1234});
        vecs.push_back('{2, 1'b1, 3'd5, 4'hF,    32'hCAFEF00D, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{2, 1'b0, 3'd5, 4'hF,    32'h0,        1'b0, 1'b1, 32'hCAFEF00D});
        vecs.push_back('{2, 1'b1, 3'd7, 4'hF,    32'h99999999, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{2, 1'b0, 3'd7, 4'hF,    32'h0,        1'b1, 1'b0, 32'h0});
        vecs.push_back('{2, 1'b1, 3'd6, 4'h3,    32'h77777777, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{2, 1'b0, 3'd5, 4'h0,    32'h0,        1'b0, 1'b1, 32'hCAFEF00D});
        for (int i = 0; i < vecs.size(); i++)
            run(vecs[i].k, vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat,
                vecs[i].exp_err, vecs[i].chk_dat, vecs[i].exp_dat, $sformatf("vec%0d", i));

        // Latency-2 abort: STB_I drops while the read is waiting, so no termination may ever follow.
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 3'd5;
        @(posedge clk); #1;
        check("abort_first_cycle_ack", 32'(ack[1] | err[1]), 32'd0);
        stb[1] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check($sformatf("abort_noack_c%0d", c), 32'(ack[1] | err[1]), 32'd0);
        end
        cyc[1] = 1'b0;
        run(1, 1'b0, 3'd5, 4'hF, 32'h0, 1'b0, 1'b1, 32'h5A5A1234, "after_abort");

        // Reset during RD_WAIT: the read is discarded and DAT_O clears.
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 3'd5;
        @(posedge clk); #1;
        rst[1] = 1'b1;
        @(posedge clk); #1;
        check("midreset_ack", 32'(ack[1] | err[1]), 32'd0);
        check("midreset_dat", dato[1], 32'd0);
        rst[1] = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
        last_dat[1] = '0;
        @(posedge clk); #1;
        check("midreset_no_late_ack", 32'(ack[1] | err[1]), 32'd0);
        run(1, 1'b0, 3'd5, 4'hF, 32'h0, 1'b0, 1'b1, 32'h5A5A1234, "after_reset");

        // Fill every implemented word, then issue random traffic against the model.
        for (int k = 0; k < NDUT; k++)
            for (int a = 0; a < DEPTH_K[k]; a++)
                run(k, 1'b1, 3'(a), 4'hF, $urandom, 1'b0, 1'b0, 32'h0, "fill");
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < NDUT; k++) begin
                logic [2:0]  a;
                bit          w;
                logic [3:0]  s;
                logic [31:0] d;
                a = 3'($urandom_range(7, 0));
                w = 1'($urandom_range(1, 0));
                s = 4'($urandom);
                d = $urandom;
                run(k, w, a, s, d, (int'(a) >= DEPTH_K[k]), model_valid[k][a],
                    model_mem[k][a], "rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
